// File: rtl/tnn_pkg.sv
// tnn_pkg: shared weight encodings, FSM states and accumulator sizing for the TNN neuron
package tnn_pkg;
  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;
  localparam logic [1:0] W_ZERO = 2'b00;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic int acc_width(int n_in, int w, int drop);
    return (w - drop) + $clog2(n_in + 1) + 1;
  endfunction
endpackage

// File: rtl/tnn_neuron_seq_if.sv
// tnn_neuron_seq_if: feature-in / decision-out valid-ready handshakes of the neuron
interface tnn_neuron_seq_if #(parameter int N_IN = 3, parameter int W = 3);
  logic in_valid;
  logic in_ready;
  logic [N_IN*W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_bit);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_bit);
endinterface

// File: rtl/tnn_mac_lane.sv
// tnn_mac_lane: ternary weight decode of one truncated feature into a signed term
module tnn_mac_lane import tnn_pkg::*; #(
  parameter int W = 3,
  parameter int DROP_LSB = 0,
  parameter int ACC_W = 6
) (
  input logic [W-1:0] x,
  input logic [1:0] w,
  output logic signed [ACC_W-1:0] term
);
  logic signed [ACC_W-1:0] mag;
  assign mag = ACC_W'(x >> DROP_LSB);
  // 2'b10 is an unused code and decodes to zero like W_ZERO
  assign term = (w == W_POS) ? mag : (w == W_NEG) ? -mag : '0;
endmodule

// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq: sequential ternary-weight threshold neuron, LANES features per cycle
module tnn_neuron_seq import tnn_pkg::*; #(
  parameter int N_IN = 3,
  parameter int W = 3,
  parameter int LANES = 1,
  parameter logic [2*N_IN-1:0] WEIGHTS = 6'h15,
  parameter int THRESH = 4,
  parameter int DROP_LSB = 0
) (
  input logic clk,
  input logic rst_n,
  tnn_neuron_seq_if.slave io,
  output logic busy
);
  localparam int ACC_W = acc_width(N_IN, W, DROP_LSB);
  localparam int BEATS = (N_IN + LANES - 1) / (LANES < 1 ? 1 : LANES);
  localparam int PW = (BEATS + 1) * LANES;
  localparam int BW = $clog2(BEATS + 1);
  localparam int IW = $clog2(PW);
  localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);
  if (LANES < 1 || LANES > N_IN || DROP_LSB < 0 || DROP_LSB >= W) begin : g_bad
    $error("tnn_neuron_seq: LANES must be 1..N_IN and DROP_LSB 0..W-1");
  end
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_i;
  logic [N_IN*W-1:0] x_q;
  logic signed [ACC_W-1:0] acc, sum;
  logic [BW-1:0] beat;
  logic fin, out_q;
  logic [W-1:0] x_arr [PW];
  logic [1:0] w_arr [PW];
  logic signed [ACC_W-1:0] terms [LANES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];
  // one spare zero-weight beat of padding covers partial final beats and the compare cycle
  for (genvar i = 0; i < PW; i++) begin : g_pad
    if (i < N_IN) begin : g_real
      assign x_arr[i] = x_q[i*W +: W];
      assign w_arr[i] = WEIGHTS[2*i +: 2];
    end else begin : g_zero
      assign x_arr[i] = '0;
      assign w_arr[i] = W_ZERO;
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = IW'(int'(beat) * LANES + k);
    tnn_mac_lane #(.W(W), .DROP_LSB(DROP_LSB), .ACC_W(ACC_W)) u_lane (
      .x(x_arr[idx]),
      .w(w_arr[idx]),
      .term(terms[k])
    );
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) sum = sum + terms[k];
  end
  assign fin = beat == BW'(BEATS);
  always_comb begin
    state_n = state;
    if (state == IDLE && io.in_valid) state_n = ACC;
    if (state == ACC && fin) state_n = DONE;
    if (state == DONE && io.out_ready) state_n = IDLE;
  end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.out_bit = out_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      x_q <= '0;
      acc <= '0;
      beat <= '0;
      out_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && io.in_valid) begin
        x_q <= io.in_data;
        acc <= '0;
        beat <= '0;
      end else if (state == ACC && !fin) begin
        acc <= acc + sum;
        beat <= beat + BW'(1);
      end
      if (state == ACC && fin) out_q <= acc >= TH;
    end
endmodule
